upsampler_hold: RTL and testbench

- Interpolating rate converter on fast_clk; the transmit-side counterpart of the receive-path decimator.
- Accepts complex 32-bit samples at a low rate (one per FACTOR cycles nominal) through a valid/ready handshake.
- Emits FACTOR output samples per input sample with a valid/ready handshake.
- Feeds the fast-rate transmit/beamforming chain.
- A small input FIFO absorbs source jitter, so bursts do not stall the output cadence.

---
 rtl/sdu_pkg.sv | 19 +
 rtl/upsampler_hold_if.sv | 31 +++
 rtl/sync_fifo_cplx.sv | 66 ++++++
 rtl/upsampler_hold.sv | 119 +++++++++++
 tb/tb_upsampler_hold.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdu_pkg.sv
// Shared definitions for the sample-domain units: default datapath width,
// the rate factor shared by the decimator and the upsampler, the complex
// sample type and the upsampler state encoding.
package sdu_pkg;

   localparam int SDU_DW          = 32;
   localparam int SDU_RATE_FACTOR = 7;

   typedef struct packed {
      logic signed [SDU_DW-1:0] re;
      logic signed [SDU_DW-1:0] im;
   } sdu_cplx_t;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } upsampler_state_t;

endpackage

// File: rtl/upsampler_hold_if.sv
// Streaming bus of the upsampler: low-rate complex input with valid/ready
// and high-rate complex output with valid/ready plus a first-replica marker.
// The slave modport is the upsampler side, master is the surrounding logic.
interface upsampler_hold_if
   import sdu_pkg::*;
#(
   parameter int DW = SDU_DW
) ();

   logic                 din_valid;
   logic                 din_ready;
   logic signed [DW-1:0] din_re;
   logic signed [DW-1:0] din_im;

   logic                 dout_valid;
   logic                 dout_ready;
   logic signed [DW-1:0] dout_re;
   logic signed [DW-1:0] dout_im;
   logic                 dout_first;

   modport slave (
      input  din_valid, din_re, din_im, dout_ready,
      output din_ready, dout_valid, dout_re, dout_im, dout_first
   );

   modport master (
      output din_valid, din_re, din_im, dout_ready,
      input  din_ready, dout_valid, dout_re, dout_im, dout_first
   );

endinterface

// File: rtl/sync_fifo_cplx.sv
// Small single-clock FIFO for packed complex samples. Flags come from a
// registered occupancy count. The head entry is read combinationally so a
// consumer can take it in the same cycle it pops; at these depths the
// storage maps to LUT RAM. DEPTH must be a power of two so the pointers
// wrap naturally.
module sync_fifo_cplx #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             fast_clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [AW:0]      count_next;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem_reg[rd_ptr_reg];

   // Storage write; contents need no reset since the count gates visibility.
   always_ff @(posedge fast_clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= wr_data;
      end
   end

   // Occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge fast_clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/upsampler_hold.sv
// Interpolating rate converter: every input sample is emitted FACTOR times
// on the fast-rate output, back to back with no bubble while the FIFO has
// data. Optional build macro UPSAMPLER_ZERO_STUFF_EN replaces phases
// 1..FACTOR-1 with zeros instead of repeating the held sample.
module upsampler_hold
   import sdu_pkg::*;
#(
   parameter int FACTOR     = SDU_RATE_FACTOR,
   parameter int DW         = SDU_DW,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             fast_clk,
   input  logic             reset,
   upsampler_hold_if.slave  bus,
   output logic             err_overflow
);

   localparam int            PW         = $clog2(FACTOR);
   localparam logic [PW-1:0] LAST_PHASE = PW'(FACTOR - 1);

   upsampler_state_t state_reg, state_next;
   logic [PW-1:0]    phase_reg, phase_next;
   logic [2*DW-1:0]  hold_reg, hold_next;
   logic             err_overflow_reg;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [2*DW-1:0]  fifo_rd_data;
   logic             emit;
   logic             stuff_zero;

   sync_fifo_cplx #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*DW)
   ) u_fifo (
      .fast_clk (fast_clk),
      .reset    (reset),
      .push     (bus.din_valid && !fifo_full),
      .wr_data  ({bus.din_re, bus.din_im}),
      .pop      (fifo_pop),
      .rd_data  (fifo_rd_data),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign bus.din_ready = !fifo_full;
   assign emit          = (state_reg == EMIT);

`ifdef UPSAMPLER_ZERO_STUFF_EN
   assign stuff_zero = (phase_reg != '0);
`else
   assign stuff_zero = 1'b0;
`endif

   assign bus.dout_valid = emit;
   assign bus.dout_first = emit && (phase_reg == '0);
   assign bus.dout_re    = (emit && !stuff_zero) ? hold_reg[2*DW-1:DW] : '0;
   assign bus.dout_im    = (emit && !stuff_zero) ? hold_reg[DW-1:0]    : '0;
   assign err_overflow   = err_overflow_reg;

   // Next-state logic: load the hold register from the FIFO head, step the
   // phase on each accepted output and chain straight into the next sample.
   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      hold_next  = hold_reg;
      fifo_pop   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               hold_next  = fifo_rd_data;
               phase_next = '0;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (bus.dout_ready) begin
               if (phase_reg != LAST_PHASE) begin
                  phase_next = phase_reg + 1'b1;
               end else begin
                  phase_next = '0;
                  if (!fifo_empty) begin
                     fifo_pop  = 1'b1;
                     hold_next = fifo_rd_data;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, phase and held-sample registers.
   always_ff @(posedge fast_clk) begin
      if (reset) begin
         state_reg <= IDLE;
         phase_reg <= '0;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         hold_reg  <= hold_next;
      end
   end

   // Sticky flag for samples offered while the FIFO was full.
   always_ff @(posedge fast_clk) begin
      if (reset) begin
         err_overflow_reg <= 1'b0;
      end else if (bus.din_valid && fifo_full) begin
         err_overflow_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_upsampler_hold.sv
// Self-checking bench for upsampler_hold: a per-cycle vector table for the
// single-sample case, hand-written sequences for the multi-cycle corners and
// a random soak against a replica scoreboard. Honors UPSAMPLER_ZERO_STUFF_EN.
module tb_upsampler_hold;
   import sdu_pkg::*;

   localparam int FACTOR = SDU_RATE_FACTOR;
   localparam int DW     = SDU_DW;
`ifdef UPSAMPLER_ZERO_STUFF_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   logic fast_clk = 1'b0;
   logic reset    = 1'b1;
   logic err_overflow;

   always #5 fast_clk = ~fast_clk;

   upsampler_hold_if #(.DW(DW)) bus ();

   upsampler_hold #(
      .FACTOR     (FACTOR),
      .DW         (DW),
      .FIFO_DEPTH (4)
   ) dut (
      .fast_clk     (fast_clk),
      .reset        (reset),
      .bus          (bus.slave),
      .err_overflow (err_overflow)
   );

   typedef struct packed {
      sdu_cplx_t d;
      logic      first;
   } exp_t;

   typedef struct packed {
      logic        din_valid;
      logic [31:0] din_re;
      logic [31:0] din_im;
      logic        dout_ready;
      logic        exp_valid;
      logic        exp_first;
      logic [31:0] exp_re;
      logic [31:0] exp_im;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   out_count;
   int   acc, stall, nvalid, first_idx, last_idx, accepted;
   vec_t vecs[10];
   logic exp_rdy[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   // Expected value of replica r of sample s.
   function automatic sdu_cplx_t replica(sdu_cplx_t s, int r);
      if (ZS && r != 0) return '0;
      return s;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // One clock: scoreboard both handshakes before the edge, then confirm a
   // stalled output held still across it.
   task automatic cycle();
      sdu_cplx_t in_s;
      sdu_cplx_t seen;
      logic      seen_first;
      logic      stalled;
      exp_t      e;
      in_s.re = bus.din_re;
      in_s.im = bus.din_im;
      if (bus.din_valid && bus.din_ready) begin
         for (int r = 0; r < FACTOR; r++) begin
            e.d     = replica(in_s, r);
            e.first = (r == 0);
            exp_q.push_back(e);
         end
      end
      if (bus.dout_valid && bus.dout_ready) begin
         out_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h%h expected none", bus.dout_re, bus.dout_im);
         end else begin
            e = exp_q.pop_front();
            check("dout_data", {bus.dout_re, bus.dout_im}, e.d);
            check("dout_first", 64'(bus.dout_first), 64'(e.first));
         end
      end
      stalled    = bus.dout_valid && !bus.dout_ready;
      seen.re    = bus.dout_re;
      seen.im    = bus.dout_im;
      seen_first = bus.dout_first;
      @(posedge fast_clk);
      #1;
      if (stalled) begin
         check("stall_valid", 64'(bus.dout_valid), 64'd1);
         check("stall_data", {bus.dout_re, bus.dout_im}, seen);
         check("stall_first", 64'(bus.dout_first), 64'(seen_first));
      end
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      bus.din_valid  = 1'b0;
      bus.din_re     = '0;
      bus.din_im     = '0;
      bus.dout_ready = 1'b0;
      repeat (2) @(posedge fast_clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_reset_state(string tag);
      check({tag, "_din_ready"}, 64'(bus.din_ready), 64'd1);
      check({tag, "_dout_valid"}, 64'(bus.dout_valid), 64'd0);
      check({tag, "_dout_data"}, {bus.dout_re, bus.dout_im}, 64'd0);
      check({tag, "_dout_first"}, 64'(bus.dout_first), 64'd0);
      check({tag, "_err"}, 64'(err_overflow), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Single-sample vector table: row k applies inputs, then checks the
      // outputs seen after the following edge.
      for (int i = 0; i < 10; i++) begin
         vecs[i].din_valid  = (i == 0);
         vecs[i].din_re     = 32'h0000_0005;
         vecs[i].din_im     = 32'hFFFF_FFFB;
         vecs[i].dout_ready = 1'b1;
         vecs[i].exp_valid  = (i >= 1 && i <= 7);
         vecs[i].exp_first  = (i == 1);
         vecs[i].exp_re     = (i == 1 || !ZS) ? 32'h0000_0005 : 32'h0;
         vecs[i].exp_im     = (i == 1 || !ZS) ? 32'hFFFF_FFFB : 32'h0;
      end

      out_count = 0;
      do_reset();
      check_reset_state("reset");

      for (int i = 0; i < 10; i++) begin
         bus.din_valid  = vecs[i].din_valid;
         bus.din_re     = vecs[i].din_re;
         bus.din_im     = vecs[i].din_im;
         bus.dout_ready = vecs[i].dout_ready;
         cycle();
         check("vec_valid", 64'(bus.dout_valid), 64'(vecs[i].exp_valid));
         check("vec_din_ready", 64'(bus.din_ready), 64'd1);
         if (vecs[i].exp_valid) begin
            check("vec_first", 64'(bus.dout_first), 64'(vecs[i].exp_first));
            check("vec_data", {bus.dout_re, bus.dout_im}, {vecs[i].exp_re, vecs[i].exp_im});
         end
      end
      check("single_drain", 64'(exp_q.size()), 64'd0);

      // Back-to-back: three pushes give 21 contiguous outputs.
      do_reset();
      bus.dout_ready = 1'b1;
      nvalid    = 0;
      first_idx = -1;
      last_idx  = -1;
      for (int c = 0; c < 35; c++) begin
         bus.din_valid = (c < 3);
         bus.din_re    = 32'(c + 1);
         bus.din_im    = -32'(c + 1);
         cycle();
         if (bus.dout_valid) begin
            if (first_idx < 0) first_idx = c;
            last_idx = c;
            nvalid++;
         end
      end
      check("b2b_count", 64'(nvalid), 64'(3 * FACTOR));
      check("b2b_contiguous", 64'(last_idx - first_idx), 64'(3 * FACTOR - 1));
      check("b2b_drain", 64'(exp_q.size()), 64'd0);

      // Backpressure: stall for 5 cycles at phase 3.
      do_reset();
      acc   = 0;
      stall = 0;
      for (int c = 0; c < 40; c++) begin
         bus.din_valid = (c == 0);
         bus.din_re    = 32'd9;
         bus.din_im    = -32'd9;
         if (bus.dout_valid && acc == 3 && stall < 5) begin
            bus.dout_ready = 1'b0;
            stall++;
         end else begin
            bus.dout_ready = 1'b1;
         end
         if (bus.dout_valid && bus.dout_ready) acc++;
         cycle();
      end
      check("bp_replicas", 64'(acc), 64'(FACTOR));
      check("bp_stall_cycles", 64'(stall), 64'd5);
      check("bp_drain", 64'(exp_q.size()), 64'd0);

      // Overflow: output blocked, six pushes, the sixth is dropped.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         bus.din_valid = 1'b1;
         bus.din_re    = 32'(100 + k);
         bus.din_im    = 32'(200 + k);
         check("ovf_din_ready", 64'(bus.din_ready), 64'(exp_rdy[k]));
         cycle();
      end
      bus.din_valid = 1'b0;
      cycle();
      check("ovf_err_set", 64'(err_overflow), 64'd1);
      repeat (3) cycle();
      check("ovf_err_sticky", 64'(err_overflow), 64'd1);
      bus.dout_ready = 1'b1;
      out_count = 0;
      repeat (60) cycle();
      check("ovf_outputs", 64'(out_count), 64'(5 * FACTOR));
      check("ovf_drain", 64'(exp_q.size()), 64'd0);
      check("ovf_err_after_drain", 64'(err_overflow), 64'd1);
      do_reset();
      check("ovf_err_cleared", 64'(err_overflow), 64'd0);

      // Reset mid-operation at phase 4 with two samples queued.
      do_reset();
      bus.dout_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 30; c++) begin
         if (acc == 4 && bus.dout_valid) break;
         bus.din_valid = (c < 3);
         bus.din_re    = 32'(50 + c);
         bus.din_im    = 32'(60 + c);
         if (bus.dout_valid && bus.dout_ready) acc++;
         cycle();
      end
      check("rst_reached_phase4", 64'(acc), 64'd4);
      bus.din_valid = 1'b0;
      reset = 1'b1;
      @(posedge fast_clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      check_reset_state("midrst");
      for (int c = 0; c < 20; c++) begin
         cycle();
         check("midrst_no_stale", 64'(bus.dout_valid), 64'd0);
      end

      // Random soak against the replica scoreboard.
      do_reset();
      accepted = 0;
      for (int c = 0; c < 3000; c++) begin
         bus.din_valid  = ($urandom_range(6) == 0);
         bus.din_re     = $urandom;
         bus.din_im     = $urandom;
         bus.dout_ready = ($urandom_range(3) != 0);
         if (bus.din_valid && bus.din_ready) accepted++;
         cycle();
      end
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b1;
      repeat (FACTOR * 8) cycle();
      check("soak_activity", 64'(accepted > 10), 64'd1);
      check("soak_drain", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
